mult_share_arbiter: RTL and testbench

- Shares one sequential multiplier (start/ready handshake) among NREQ requesters.
- Each requester presents operands and holds req; the arbiter grants round-robin, launches the multiplier and waits for completion.
- On completion it returns the product with a one-cycle done pulse to the winner.
- Sits between the requesting datapaths and the multiplier top (multiplier controller plus its datapath).

---
 rtl/mult_arb_pkg.sv | 13 +
 rtl/rr_picker.sv | 22 ++
 rtl/mult_share_arbiter.sv | 104 ++++++++++
 tb/tb_mult_share_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: shared state encoding and default sizing for mult_share_arbiter.
package mult_arb_pkg;
    localparam int NREQ_DEF    = 4;
    localparam int WIDTH_DEF   = 4;
    localparam int TIMEOUT_DEF = 32;
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        RESP      = 3'd4
    } state_t;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin select, first set req bit at or above ptr, wrapping.
module rr_picker #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            found,
    output logic [IW-1:0]   idx
);
    // Scan from the farthest offset down so the nearest hit to ptr wins.
    always_comb begin
        found = 1'b0;
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NREQ]) begin
                found = 1'b1;
                idx = IW'((int'(ptr) + k) % NREQ);
            end
        end
    end
endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one start/ready multiplier among NREQ requesters.
// Define MULT_ARB_TIMEOUT_EN to add the wait watchdog and the sticky err flag.
module mult_share_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int WIDTH   = WIDTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a_in,
    input  logic [NREQ*WIDTH-1:0] b_in,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic [2*WIDTH-1:0]    result,
    output logic                  busy,
    output logic                  mul_start,
    output logic [WIDTH-1:0]      mul_a,
    output logic [WIDTH-1:0]      mul_b,
    input  logic                  mul_ready,
    input  logic [2*WIDTH-1:0]    mul_product,
    output logic                  err
);
    localparam int IW = $clog2(NREQ);
    state_t state, state_nx;
    logic [IW-1:0] ptr, owner, idx;
    logic found, ok, to;
    logic [NREQ-1:0] oh;

    rr_picker #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req(req),
        .ptr(ptr),
        .found(found),
        .idx(idx)
    );

    assign oh = NREQ'(1) << owner;
    assign ok = state == WAIT_DONE && mul_ready;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    // A genuine completion in the same cycle as the limit takes precedence.
    assign to = (state == WAIT_BUSY || state == WAIT_DONE) && cnt == CW'(TIMEOUT - 1) && !ok;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            cnt <= (state == WAIT_BUSY || state == WAIT_DONE) ? cnt + 1'b1 : '0;
            if (to) err <= 1'b1;
        end
    end
`else
    assign to = 1'b0;
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end

    // WAIT_BUSY ignores a ready level left over from before the start pulse.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      state_nx = (found && mul_ready) ? LAUNCH : IDLE;
            LAUNCH:    state_nx = WAIT_BUSY;
            WAIT_BUSY: state_nx = to ? RESP : (mul_ready ? WAIT_BUSY : WAIT_DONE);
            WAIT_DONE: state_nx = (ok || to) ? RESP : WAIT_DONE;
            RESP:      state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
            owner <= '0;
            mul_a <= '0;
            mul_b <= '0;
            result <= '0;
        end else begin
            if (state == IDLE && found && mul_ready) begin
                owner <= idx;
                mul_a <= a_in[int'(idx)*WIDTH +: WIDTH];
                mul_b <= b_in[int'(idx)*WIDTH +: WIDTH];
            end
            if (ok) result <= mul_product;
            else if (to) result <= '0;
            if (state == RESP) ptr <= (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
        end
    end

    always_comb begin
        busy = state != IDLE;
        mul_start = state == LAUNCH;
        gnt = busy ? oh : '0;
        done = (state == RESP) ? oh : '0;
    end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: scoreboard bench with a behavioural start/ready multiplier model.
module tb_mult_share_arbiter;
    localparam int N = 4;
    localparam int W = 4;
    localparam int W2 = 2 * W;

    typedef struct {
        int idx;
        logic [W2-1:0] prod;
    } exp_t;

    logic clk, rst;
    logic [N-1:0] req, gnt, done;
    logic [N*W-1:0] a_in, b_in;
    logic [W2-1:0] result, mul_product;
    logic busy, mul_start, mul_ready, err;
    logic [W-1:0] mul_a, mul_b;

    logic m_ready, hold_low, stuck;
    logic [W2-1:0] m_prod;
    int m_cnt, lat;
    int cyc, starts, rise_cyc;
    logic prev_rdy;
    int checks, errors;
    exp_t sb[$];

    mult_share_arbiter #(.NREQ(N), .WIDTH(W), .TIMEOUT(32)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .a_in(a_in),
        .b_in(b_in),
        .gnt(gnt),
        .done(done),
        .result(result),
        .busy(busy),
        .mul_start(mul_start),
        .mul_a(mul_a),
        .mul_b(mul_b),
        .mul_ready(mul_ready),
        .mul_product(mul_product),
        .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ready <= 1'b1;
            m_cnt <= 0;
            m_prod <= '0;
        end else if (mul_start) begin
            m_ready <= 1'b0;
            m_cnt <= lat;
            m_prod <= W2'(mul_a) * W2'(mul_b);
        end else if (m_cnt > 1) begin
            m_cnt <= m_cnt - 1;
        end else if (m_cnt == 1 && !stuck) begin
            m_cnt <= 0;
            m_ready <= 1'b1;
        end
    end
    assign mul_ready = m_ready && !hold_low;
    assign mul_product = m_prod;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mul_start) starts <= starts + 1;
        if (mul_ready && !prev_rdy) rise_cyc <= cyc;
        prev_rdy <= mul_ready;
    end

    task automatic set_op(input int i, input int a, input int b);
        a_in[i*W +: W] = W'(a);
        b_in[i*W +: W] = W'(b);
    endtask

    task automatic push_exp(input int i, input int p);
        exp_t e;
        e.idx = i;
        e.prod = W2'(p);
        sb.push_back(e);
    endtask

    task automatic wait_done(output logic [N-1:0] d, output logic [W2-1:0] r, output int at, output bit got);
        d = '0;
        r = '0;
        at = 0;
        got = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (done != 0) begin
                d = done;
                r = result;
                at = cyc;
                got = 1;
                break;
            end
        end
    endtask

    task automatic wait_start(output int at);
        at = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (mul_start) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1;
        req = '1;
        repeat (2) @(negedge clk);
        checks++;
        if ({gnt, done, busy, mul_start, err} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: gnt=%b done=%b busy=%b start=%b err=%b required all 0", gnt, done, busy, mul_start, err);
        end
        checks++;
        if ({mul_a, mul_b, result} !== '0) begin
            errors++;
            $display("FAIL reset_data: mul_a=%0d mul_b=%0d result=%0d required 0", mul_a, mul_b, result);
        end
        req = '0;
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_single;
        logic [N-1:0] d, eoh;
        logic [W2-1:0] r;
        int at, sa, s0;
        bit got;
        exp_t e;
        lat = 8;
        set_op(2, 5, 3);
        push_exp(2, 15);
        s0 = starts;
        req = 4'b0100;
        wait_start(sa);
        checks++;
        if (sa < 0 || gnt !== 4'b0100 || mul_a !== 4'd5 || mul_b !== 4'd3) begin
            errors++;
            $display("FAIL single_launch: gnt=%b mul_a=%0d mul_b=%0d required gnt=0100 a=5 b=3", gnt, mul_a, mul_b);
        end
        wait_done(d, r, at, got);
        req = '0;
        e = sb.pop_front();
        eoh = N'(1) << e.idx;
        checks++;
        if (!got || d !== eoh || r !== e.prod) begin
            errors++;
            $display("FAIL single_done: done=%b result=%0d required done=%b result=%0d", d, r, eoh, e.prod);
        end
        checks++;
        if (at - rise_cyc != 1) begin
            errors++;
            $display("FAIL single_latency: done %0d cycles after ready rise, required 1", at - rise_cyc);
        end
        checks++;
        if (starts - s0 != 1) begin
            errors++;
            $display("FAIL single_start_pulses: got %0d required 1", starts - s0);
        end
    endtask

    task automatic test_round_robin;
        logic [N-1:0] d, eoh;
        logic [W2-1:0] r;
        int at, prev;
        bit got;
        exp_t e;
        rst = 1;
        @(negedge clk);
        rst = 0;
        lat = 3;
        for (int i = 0; i < N; i++) set_op(i, i + 2, i + 5);
        for (int n = 0; n < 5; n++) push_exp(n % N, (n % N + 2) * (n % N + 5));
        req = '1;
        prev = 0;
        for (int n = 0; n < 5; n++) begin
            wait_done(d, r, at, got);
            if (n == 4) req = '0;
            e = sb.pop_front();
            eoh = N'(1) << e.idx;
            checks++;
            if (!got || d !== eoh || r !== e.prod) begin
                errors++;
                $display("FAIL rr_grant_%0d: done=%b result=%0d required done=%b result=%0d", n, d, r, eoh, e.prod);
            end
            if (n > 0) begin
                checks++;
                if (at - prev != lat + 4) begin
                    errors++;
                    $display("FAIL rr_turnaround_%0d: got %0d cycles required %0d", n, at - prev, lat + 4);
                end
            end
            prev = at;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_idle_after: busy=%b required 0", busy);
        end
    endtask

    task automatic test_drop;
        logic [N-1:0] d, eoh;
        logic [W2-1:0] r;
        int at, sa;
        bit got;
        exp_t e;
        lat = 6;
        set_op(1, 15, 15);
        push_exp(1, 225);
        req = 4'b0010;
        wait_start(sa);
        repeat (2) @(negedge clk);
        req = '0;
        set_op(1, 0, 0);
        wait_done(d, r, at, got);
        e = sb.pop_front();
        eoh = N'(1) << e.idx;
        checks++;
        if (sa < 0 || !got || d !== eoh || r !== e.prod) begin
            errors++;
            $display("FAIL drop_done: done=%b result=%0d required done=%b result=%0d", d, r, eoh, e.prod);
        end
    endtask

    task automatic test_ready_low;
        logic [N-1:0] d, eoh;
        logic [W2-1:0] r;
        int at;
        bit got, bad;
        exp_t e;
        lat = 2;
        hold_low = 1;
        set_op(0, 7, 9);
        push_exp(0, 63);
        req = 4'b0001;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (gnt != 0 || mul_start || busy) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL ready_low_hold: granted while ready low (gnt=%b busy=%b) required no grant", gnt, busy);
        end
        hold_low = 0;
        wait_done(d, r, at, got);
        req = '0;
        e = sb.pop_front();
        eoh = N'(1) << e.idx;
        checks++;
        if (!got || d !== eoh || r !== e.prod) begin
            errors++;
            $display("FAIL ready_low_done: done=%b result=%0d required done=%b result=%0d", d, r, eoh, e.prod);
        end
    endtask

    task automatic test_reset_mid;
        logic [N-1:0] d, eoh;
        logic [W2-1:0] r;
        int at, sa;
        bit got;
        exp_t e;
        lat = 20;
        set_op(3, 6, 6);
        req = 4'b1000;
        wait_start(sa);
        repeat (3) @(negedge clk);
        checks++;
        if (sa < 0 || busy !== 1'b1 || mul_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_wait: busy=%b ready=%b required busy=1 ready=0", busy, mul_ready);
        end
        rst = 1;
        req = '0;
        #1;
        checks++;
        if ({gnt, done, busy, mul_start} !== '0) begin
            errors++;
            $display("FAIL mid_reset: gnt=%b done=%b busy=%b start=%b required all 0", gnt, done, busy, mul_start);
        end
        @(negedge clk);
        rst = 0;
        lat = 2;
        set_op(0, 2, 11);
        set_op(3, 13, 4);
        push_exp(0, 22);
        push_exp(3, 52);
        req = 4'b1001;
        for (int n = 0; n < 2; n++) begin
            wait_done(d, r, at, got);
            req = req & ~d;
            e = sb.pop_front();
            eoh = N'(1) << e.idx;
            checks++;
            if (!got || d !== eoh || r !== e.prod) begin
                errors++;
                $display("FAIL post_reset_%0d: done=%b result=%0d required done=%b result=%0d", n, d, r, eoh, e.prod);
            end
        end
        req = '0;
    endtask

`ifdef MULT_ARB_TIMEOUT_EN
    task automatic test_timeout;
        logic [N-1:0] d, eoh;
        logic [W2-1:0] r;
        int at, sa;
        bit got;
        exp_t e;
        rst = 1;
        @(negedge clk);
        rst = 0;
        stuck = 1;
        lat = 2;
        set_op(0, 3, 3);
        push_exp(0, 0);
        req = 4'b0001;
        wait_start(sa);
        wait_done(d, r, at, got);
        req = '0;
        e = sb.pop_front();
        eoh = N'(1) << e.idx;
        checks++;
        if (sa < 0 || !got || d !== eoh || r !== e.prod || err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_done: done=%b result=%0d err=%b required done=%b result=0 err=1", d, r, err, eoh);
        end
        checks++;
        if (at - sa != 33) begin
            errors++;
            $display("FAIL timeout_cycles: done %0d cycles after start, required 33", at - sa);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: err=%b required 1", err);
        end
        rst = 1;
        stuck = 0;
        #1;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: err=%b required 0", err);
        end
        @(negedge clk);
        rst = 0;
    endtask
`endif

    initial begin
        clk = 0;
        rst = 1;
        req = '0;
        a_in = '0;
        b_in = '0;
        hold_low = 0;
        stuck = 0;
        lat = 4;
        cyc = 0;
        starts = 0;
        rise_cyc = 0;
        prev_rdy = 1;
        checks = 0;
        errors = 0;
        test_reset;
        test_single;
        test_round_robin;
        test_drop;
        test_ready_low;
        test_reset_mid;
`ifdef MULT_ARB_TIMEOUT_EN
        test_timeout;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
